// File: rtl/fp_cmp_pkg.sv
// Shared definitions for the floating-point compare pipeline.
//   OP_LT..OP_MAX : operation select encodings (5..7 are reserved)
//   canon_nan()   : builds the canonical quiet NaN pattern for any
//                   exponent/mantissa split (sign 0, exponent all ones,
//                   mantissa MSB 1, remaining mantissa bits 0). The result
//                   sits in the low 1+exp_w+mant_w bits of a MAX_W vector.
package fp_cmp_pkg;

  localparam logic [2:0] OP_LT  = 3'd0;
  localparam logic [2:0] OP_LE  = 3'd1;
  localparam logic [2:0] OP_EQ  = 3'd2;
  localparam logic [2:0] OP_MIN = 3'd3;
  localparam logic [2:0] OP_MAX = 3'd4;

  localparam int MAX_W = 128;

  function automatic logic [MAX_W-1:0] canon_nan(input int exp_w, input int mant_w);
    logic [MAX_W-1:0] r;
    r = '0;
    // Bits mant_w-1 (quiet bit) up to mant_w+exp_w-1 (exponent MSB) are set.
    for (int i = 0; i < MAX_W; i++) begin
      if (i >= mant_w - 1 && i < mant_w + exp_w) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational classification of one IEEE-754 style operand.
//   x       : operand {sign, exponent, mantissa}
//   is_nan  : exponent all ones and mantissa non-zero
//   is_zero : exponent and mantissa zero (either sign)
//   sign    : sign bit
//   key     : magnitude key {exponent, mantissa}; orders magnitudes
//             (subnormals and infinities included) as an unsigned number
module fp_classify #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic [EXP_W+MANT_W:0]   x,
  output logic                    is_nan,
  output logic                    is_zero,
  output logic                    sign,
  output logic [EXP_W+MANT_W-1:0] key
);

  logic [EXP_W-1:0]  exp_f;
  logic [MANT_W-1:0] mant_f;

  assign {sign, exp_f, mant_f} = x;
  assign key     = {exp_f, mant_f};
  assign is_nan  = (&exp_f) & (|mant_f);
  assign is_zero = ~(|key);

endmodule

// File: rtl/fp_compare_pipe.sv
// Two-stage pipelined floating-point comparator / min-max selector.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake for an operand pair
//   in_a, in_b            : operands (1+EXP_W+MANT_W bits)
//   in_op                 : 0 LT, 1 LE, 2 EQ, 3 MIN, 4 MAX, 5-7 reserved
//   in_tag                : sideband tag, carried unchanged
//   out_valid/out_ready   : output handshake
//   out_flag              : compare result, or "A selected" for MIN/MAX
//   out_value             : MIN/MAX result, otherwise in_a unchanged
//   out_unord             : at least one operand is NaN
//   out_tag               : tag belonging to this result
module fp_compare_pipe
  import fp_cmp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int TAG_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MANT_W:0]   in_a,
  input  logic [EXP_W+MANT_W:0]   in_b,
  input  logic [2:0]              in_op,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_flag,
  output logic [EXP_W+MANT_W:0]   out_value,
  output logic                    out_unord,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int W = 1 + EXP_W + MANT_W;
  localparam int K = EXP_W + MANT_W;
  localparam logic [MAX_W-1:0] QNAN_FULL = canon_nan(EXP_W, MANT_W);
  localparam logic [W-1:0]     QNAN      = QNAN_FULL[W-1:0];

  logic         a_nan, a_zero, a_sign;
  logic         b_nan, b_zero, b_sign;
  logic [K-1:0] a_key, b_key;

  fp_classify #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_cls_a (
    .x(in_a), .is_nan(a_nan), .is_zero(a_zero), .sign(a_sign), .key(a_key)
  );
  fp_classify #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_cls_b (
    .x(in_b), .is_nan(b_nan), .is_zero(b_zero), .sign(b_sign), .key(b_key)
  );

  logic adv_p1, adv_p2;
  logic vld_p1_q, vld_p2_q;

  // Stage 2 may always refill when empty, so bubbles collapse even while
  // the consumer stalls.
  assign adv_p2   = ~vld_p2_q | out_ready;
  assign adv_p1   = ~vld_p1_q | adv_p2;
  assign in_ready = adv_p1;

  // ---- stage 1: operands, classification and key comparison ----
  logic [W-1:0]     a_p1_q, b_p1_q;
  logic [2:0]       op_p1_q;
  logic [TAG_W-1:0] tag_p1_q;
  logic             a_nan_p1_q, b_nan_p1_q, a_zero_p1_q, b_zero_p1_q;
  logic             a_sign_p1_q, b_sign_p1_q, key_lt_p1_q, key_eq_p1_q;

  always_ff @(posedge clk) begin
    if (rst) vld_p1_q <= 1'b0;
    else if (adv_p1) vld_p1_q <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid && adv_p1) begin
      a_p1_q      <= in_a;
      b_p1_q      <= in_b;
      op_p1_q     <= in_op;
      tag_p1_q    <= in_tag;
      a_nan_p1_q  <= a_nan;
      b_nan_p1_q  <= b_nan;
      a_zero_p1_q <= a_zero;
      b_zero_p1_q <= b_zero;
      a_sign_p1_q <= a_sign;
      b_sign_p1_q <= b_sign;
      key_lt_p1_q <= (a_key < b_key);
      key_eq_p1_q <= (a_key == b_key);
    end
  end

  logic         unord_d, flag_d;
  logic [W-1:0] value_d;
  logic         both_zero, lt, eq, sel_a;

  always_comb begin
    unord_d   = a_nan_p1_q | b_nan_p1_q;
    both_zero = a_zero_p1_q & b_zero_p1_q;
    eq        = ~unord_d & (both_zero | ((a_sign_p1_q == b_sign_p1_q) & key_eq_p1_q));
    // Sign resolution: +0/-0 are equal; between negatives the larger
    // magnitude is the smaller number.
    if (unord_d | both_zero)           lt = 1'b0;
    else if (a_sign_p1_q != b_sign_p1_q) lt = a_sign_p1_q;
    else if (!a_sign_p1_q)             lt = key_lt_p1_q;
    else                               lt = ~key_lt_p1_q & ~key_eq_p1_q;

    sel_a   = 1'b0;
    flag_d  = 1'b0;
    value_d = a_p1_q;
    case (op_p1_q)
      OP_LT: flag_d = lt;
      OP_LE: flag_d = lt | eq;
      OP_EQ: flag_d = eq;
      OP_MIN, OP_MAX: begin
        if (a_nan_p1_q && b_nan_p1_q) begin
          value_d = QNAN;
        end else if (a_nan_p1_q) begin
          value_d = b_p1_q;
        end else if (b_nan_p1_q) begin
          flag_d  = 1'b1;
        end else begin
          // Ties (including +0 vs -0) keep A.
          sel_a   = (op_p1_q == OP_MIN) ? (lt | eq) : ~lt;
          flag_d  = sel_a;
          value_d = sel_a ? a_p1_q : b_p1_q;
        end
      end
      default: ;
    endcase
  end

  // ---- stage 2: final result registers ----
  logic             flag_p2_q, unord_p2_q;
  logic [W-1:0]     value_p2_q;
  logic [TAG_W-1:0] tag_p2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q   <= 1'b0;
      flag_p2_q  <= 1'b0;
      value_p2_q <= '0;
      unord_p2_q <= 1'b0;
      tag_p2_q   <= '0;
    end else if (adv_p2) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        flag_p2_q  <= flag_d;
        value_p2_q <= value_d;
        unord_p2_q <= unord_d;
        tag_p2_q   <= tag_p1_q;
      end
    end
  end

  assign out_valid = vld_p2_q;
  assign out_flag  = flag_p2_q;
  assign out_value = value_p2_q;
  assign out_unord = unord_p2_q;
  assign out_tag   = tag_p2_q;

endmodule

// File: doc/fp_compare_pipe.md
# fp_compare_pipe

Parametrised, pipelined IEEE-754 binary comparator and min/max selector with a valid/ready stream interface and a pass-through tag. It generalises the team's single-precision combinational less-than to arbitrary exponent/mantissa widths and adds operation select, correct signed-zero and NaN handling, and a 2-stage backpressured pipeline. It sits in the force pipeline wherever particle distances, cutoff tests or reductions need float ordering.

## Interface
- EXP_W, 8, exponent width
- MANT_W, 23, stored mantissa width; W = 1+EXP_W+MANT_W
- TAG_W, 16, sideband tag width (≥1), carried unchanged
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts pair this cycle
- in_a  in  W  operand A
- in_b  in  W  operand B
- in_op  in  3  operation: 0 LT, 1 LE, 2 EQ, 3 MIN, 4 MAX; 5–7 reserved
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_flag  out  1  boolean result (LT/LE/EQ); for MIN/MAX, 1 when A was selected
- out_value  out  W  MIN/MAX result; for LT/LE/EQ equals in_a unchanged
- out_unord  out  1  at least one operand NaN
- out_tag  out  TAG_W  tag of this result

## Operation
- Transfer on in_valid&in_ready; output transfer on out_valid&out_ready.
- NaN: exponent all ones, mantissa ≠ 0. Zero: exponent and mantissa 0; +0 and −0 compare equal.
- Ordering via magnitude key {exp,mant} compared unsigned; signs resolve as: differing signs → negative less unless both zero; both negative → larger key is less.
- Subnormals and infinities ordered naturally by the key; no flush.
- Unordered (either NaN): LT, LE, EQ → out_flag=0, out_unord=1.
- MIN/MAX: exactly one NaN → return the other operand, out_flag=1 iff A returned; both NaN → canonical quiet NaN (sign 0, exp all ones, mant MSB 1, rest 0), out_flag=0; out_unord=1 in both cases.
- MIN/MAX with A==B (including ±0): return A, out_flag=1; MIN(+0,−0) and MAX(+0,−0) both return A.
- Reserved op: out_flag=0, out_value=in_a, out_unord per operands.
- Stage 1 registers operands, op, tag, NaN/zero flags, sign and key-compare results (a_key_lt, a_key_eq). Stage 2 registers final flag/value/unord.

## Timing
- Latency 2 cycles accept→out_valid with no stall; throughput 1 per cycle.
- s2 advances when ~s2_valid|out_ready; s1 advances when ~s1_valid|s2 advance; in_ready = ~s1_valid | s2 advance (combinational from out_ready; no combinational in→out data path).
- Held results keep out_value/out_flag/out_unord/out_tag stable while out_valid&~out_ready.
- Bubbles collapse: an empty s2 accepts s1 even when out_ready=0.
- Reset: out_valid=0, out_flag=0, out_value=0, out_unord=0, out_tag=0, internal valids 0; in_ready=1 the cycle after reset deasserts. Reset mid-operation drops all in-flight pairs with no output.
- Simultaneous accept and emit in one cycle permitted with full throughput.

## Structure
- Package fp_cmp_pkg: op encoding constants (OP_LT..OP_MAX), canonical-NaN builder function parametrised by EXP_W/MANT_W.
- Sub-module fp_classify (combinational, per operand): is_nan, is_zero, sign, key; instantiated twice in stage 1.
- Top holds the two pipeline registers and handshake logic.

## Test plan
- LT, a=0xBF800000 (−1.0), b=0x3F800000 (1.0), out_ready=1 → out_flag=1 exactly 2 cycles after accept, out_unord=0.
- EQ a=0x80000000, b=0x00000000 → out_flag=1; LT same pair → 0; MIN → out_value=0x80000000, out_flag=1.
- MAX a=0x7FC00001 (NaN), b=0x40000000 → out_value=0x40000000, out_flag=0, out_unord=1; MAX both NaN → 0x7FC00000.
- Stream 8 pairs back-to-back, out_ready low cycles 3–6 → no loss/duplication, tags 0..7 emerge in order, in_ready low only while both stages full.
- Params EXP_W=5, MANT_W=10: LE a=0x0001 (min subnormal), b=0x0000 → 0; a=0x7C00 (+inf), b=0x7BFF → LT 0, LE 0, MAX returns 0x7C00.
- Assert rst with two pairs in flight → next cycle out_valid=0, out_value=0, out_tag=0; no stale result after release.
